// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - STEP/DIR pulse generator with driver timing enforcement.
// Optional signed position counter enabled by defining STEPGEN_POSCNT_EN.
module step_pulse_gen #(
  parameter int WIDTH_N    = 24,
  parameter int PULSE_W    = 100,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 500
`ifdef STEPGEN_POSCNT_EN
  , parameter int POS_W    = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir_req,
  input  logic [WIDTH_N-1:0] period,
  output logic               step,
  output logic               dir,
  output logic               drv_en,
  output logic               busy,
  output logic               step_done
`ifdef STEPGEN_POSCNT_EN
  , output logic [POS_W-1:0] pos
`endif
);

  if (MIN_PERIOD <= PULSE_W + 1 || DIR_SETUP < 1) begin : g_param_check
    $fatal(1, "step_pulse_gen: MIN_PERIOD must exceed PULSE_W+1 and DIR_SETUP must be >= 1");
  end

  // Shared counter must hold the longest LOW wait as well as the setup and pulse loads.
  localparam int CW_A = (WIDTH_N > $clog2(DIR_SETUP + 1)) ? WIDTH_N : $clog2(DIR_SETUP + 1);
  localparam int CW   = (CW_A > $clog2(PULSE_W + 1)) ? CW_A : $clog2(PULSE_W + 1);

  localparam logic [CW-1:0]      SETUP_LD = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0]      HIGH_LD  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]      LOW_SUB  = CW'(PULSE_W + 1);
  localparam logic [WIDTH_N-1:0] MIN_P    = WIDTH_N'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] per_r;

  logic               run_ok;
  logic               setup_done;
  logic               low_done;
  logic               rise_now;
  logic [WIDTH_N-1:0] per_next;

  assign run_ok     = enable && (period != '0);
  assign setup_done = (state == SETUP) && (cnt == '0);
  assign low_done   = (state == LOW) && (cnt == '0);
  // A LOW end only rises directly when neither stop nor direction change wins.
  assign rise_now   = setup_done || (low_done && run_ok && (dir_req == dir));
  assign per_next   = (period < MIN_P) ? MIN_P : period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      per_r     <= '0;
      step      <= 1'b0;
      dir       <= 1'b0;
      drv_en    <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run_ok) begin
            dir    <= dir_req;
            drv_en <= 1'b1;
            busy   <= 1'b1;
            cnt    <= SETUP_LD;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        HIGH: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            step      <= 1'b0;
            step_done <= 1'b1;
            cnt       <= CW'(per_r) - LOW_SUB;
            state     <= LOW;
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!run_ok) begin
            drv_en <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (dir_req != dir) begin
            dir   <= dir_req;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase

      if (rise_now) begin
        per_r <= per_next;
        step  <= 1'b1;
        cnt   <= HIGH_LD;
        state <= HIGH;
      end
    end
  end

`ifdef STEPGEN_POSCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (rise_now) begin
      pos <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
    end
  end
`endif

endmodule
